// File: rtl/counter_event_capture_pkg.sv
// Shared event codes and the event record layout for the counter event monitor.
package counter_evt_pkg;

  localparam logic [1:0] EVT_OVF  = 2'b01;
  localparam logic [1:0] EVT_THR  = 2'b10;
  localparam logic [1:0] EVT_WRAP = 2'b11;

  localparam int unsigned STAMP_W = 16;

  typedef struct packed {
    logic [1:0]         code;
    logic [7:0]         data;
    logic [STAMP_W-1:0] stamp;
  } evt_t;

endpackage

// File: rtl/counter_event_capture_if.sv
// Event drain channel: valid/ready handshake carrying the head event of the queue.
interface counter_event_capture_if #(
  parameter int unsigned STAMP_W = 16
) ();

  logic               evt_valid_out;
  logic [1:0]         evt_code_out;
  logic [7:0]         evt_data_out;
  logic [STAMP_W-1:0] evt_stamp_out;
  logic               evt_ready_in;

  modport master (
    output evt_valid_out, evt_code_out, evt_data_out, evt_stamp_out,
    input  evt_ready_in
  );

  modport slave (
    input  evt_valid_out, evt_code_out, evt_data_out, evt_stamp_out,
    output evt_ready_in
  );

endinterface

// File: rtl/counter_event_capture_fifo.sv
// Synchronous FIFO; pointers carry one extra MSB so full and empty are distinct.
module evt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 26
) (
  input  logic             clk_in,
  input  logic             nrst_in,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the write lands in.
    do_push = push & (~full | do_pop);
    rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/counter_event_capture.sv
// Counter monitor: detects overflow, wrap and threshold events, timestamps them
// and queues them for the status logic; lost events are counted.
module counter_event_capture
  import counter_evt_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned STAMP_W = 16
) (
  input  logic                    clk_in,
  input  logic                    nrst_in,
  input  logic [7:0]              cnt_in,
  input  logic                    ovf_in,
  input  logic [7:0]              thr_in,
  input  logic                    thr_en_in,
  counter_event_capture_if.master evt,
  output logic                    fifo_full_out,
  output logic [7:0]              drop_cnt_out
);

  localparam int unsigned WIDTH = 10 + STAMP_W;

  typedef struct packed {
    logic [1:0]         code;
    logic [7:0]         data;
    logic [STAMP_W-1:0] stamp;
  } entry_t;

  logic [7:0]         prev_cnt;
  logic               prev_ovf;
  logic [STAMP_W-1:0] stamp;
  logic               ovf_det;
  logic               wrap_det;
  logic               thr_det;
  logic [1:0]         n_det;
  logic [1:0]         code;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [1:0]         loss;
  logic [8:0]         drop_sum;
  entry_t             wr_entry;
  entry_t             rd_entry;

  always_comb begin
    ovf_det  = ovf_in & ~prev_ovf;
    wrap_det = ((prev_cnt == 8'hFF) && (cnt_in == 8'h00)) ||
               ((prev_cnt == 8'h00) && (cnt_in == 8'hFF));
    thr_det  = thr_en_in && (cnt_in == thr_in) && (prev_cnt != thr_in);
    n_det    = 2'(ovf_det) + 2'(wrap_det) + 2'(thr_det);

    code = '0;
    if (ovf_det)       code = EVT_OVF;
    else if (wrap_det) code = EVT_WRAP;
    else if (thr_det)  code = EVT_THR;

    pop  = ~empty & evt.evt_ready_in;
    push = (n_det != 2'd0) & (~full | pop);
    // Every detected event that did not make it into the queue is a loss.
    loss     = n_det - 2'(push);
    drop_sum = {1'b0, drop_cnt_out} + 9'(loss);

    wr_entry.code  = code;
    wr_entry.data  = cnt_in;
    wr_entry.stamp = stamp;
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      prev_cnt     <= '0;
      prev_ovf     <= 1'b0;
      stamp        <= '0;
      drop_cnt_out <= '0;
    end else begin
      prev_cnt     <= cnt_in;
      prev_ovf     <= ovf_in;
      stamp        <= stamp + 1'b1;
      drop_cnt_out <= drop_sum[8] ? '1 : drop_sum[7:0];
    end
  end

  evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .nrst_in (nrst_in),
    .push    (push),
    .pop     (pop),
    .wdata   (wr_entry),
    .rdata   (rd_entry),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    evt.evt_valid_out = ~empty;
    evt.evt_code_out  = rd_entry.code;
    evt.evt_data_out  = rd_entry.data;
    evt.evt_stamp_out = rd_entry.stamp;
    fifo_full_out     = full;
  end

endmodule

// File: tb/tb_counter_event_capture.sv
// Directed bench for counter_event_capture with hand-computed expected events.
module tb_counter_event_capture;
  import counter_evt_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned SW    = 16;

  logic       clk_in = 1'b0;
  logic       nrst_in;
  logic [7:0] cnt_in;
  logic       ovf_in;
  logic [7:0] thr_in;
  logic       thr_en_in;
  logic       fifo_full_out;
  logic [7:0] drop_cnt_out;

  counter_event_capture_if #(.STAMP_W(SW)) evt_if ();

  counter_event_capture #(
    .DEPTH   (DEPTH),
    .STAMP_W (SW)
  ) dut (
    .clk_in        (clk_in),
    .nrst_in       (nrst_in),
    .cnt_in        (cnt_in),
    .ovf_in        (ovf_in),
    .thr_in        (thr_in),
    .thr_en_in     (thr_en_in),
    .evt           (evt_if),
    .fifo_full_out (fifo_full_out),
    .drop_cnt_out  (drop_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;
  int edges   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk_in);
    #1;
    edges++;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(evt_if.evt_valid_out), 32'd0);
    check({tag, "_code"},  32'(evt_if.evt_code_out),  32'd0);
    check({tag, "_data"},  32'(evt_if.evt_data_out),  32'd0);
    check({tag, "_stamp"}, 32'(evt_if.evt_stamp_out), 32'd0);
    check({tag, "_full"},  32'(fifo_full_out),        32'd0);
    check({tag, "_drop"},  32'(drop_cnt_out),         32'd0);
  endtask

  task automatic check_head(input string tag, input logic [1:0] code,
                            input logic [7:0] data, input int stamp);
    check({tag, "_valid"}, 32'(evt_if.evt_valid_out), 32'd1);
    check({tag, "_code"},  32'(evt_if.evt_code_out),  32'(code));
    check({tag, "_data"},  32'(evt_if.evt_data_out),  32'(data));
    check({tag, "_stamp"}, 32'(evt_if.evt_stamp_out), 32'(stamp));
  endtask

  initial begin
    int st;
    int sa;
    int stq [4];
    logic [7:0] exp5 [4];

    nrst_in   = 1'b0;
    cnt_in    = 8'h00;
    ovf_in    = 1'b0;
    thr_in    = 8'h00;
    thr_en_in = 1'b0;
    evt_if.evt_ready_in = 1'b0;

    #12;
    check_idle("reset");
    @(posedge clk_in);
    #1;
    nrst_in = 1'b1;
    edges   = 0;

    // Plain ramp, threshold disabled: nothing happens.
    for (int i = 0; i <= 5; i++) begin
      cnt_in = 8'(i);
      step();
    end
    check("ramp_valid", 32'(evt_if.evt_valid_out), 32'd0);
    check("ramp_drop",  32'(drop_cnt_out),         32'd0);

    // Threshold match at 0x03, then hold.
    thr_in = 8'h03;
    thr_en_in = 1'b1;
    evt_if.evt_ready_in = 1'b1;
    for (int i = 0; i <= 2; i++) begin
      cnt_in = 8'(i);
      step();
    end
    check("thr_pre_valid", 32'(evt_if.evt_valid_out), 32'd0);
    cnt_in = 8'h03;
    st = edges;
    step();
    check_head("thr", EVT_THR, 8'h03, st);
    for (int i = 0; i < 3; i++) step();
    check("thr_hold_valid", 32'(evt_if.evt_valid_out), 32'd0);
    check("thr_hold_drop",  32'(drop_cnt_out),         32'd0);
    thr_en_in = 1'b0;
    evt_if.evt_ready_in = 1'b0;

    // Overflow at 0xFF, then wrap to 0x00 on the next edge.
    cnt_in = 8'hFD; step();
    cnt_in = 8'hFE; step();
    cnt_in = 8'hFF; ovf_in = 1'b1;
    sa = edges;
    step();
    cnt_in = 8'h00; ovf_in = 1'b0;
    step();
    check_head("ovf", EVT_OVF, 8'hFF, sa);
    evt_if.evt_ready_in = 1'b1;
    step();
    check_head("wrap", EVT_WRAP, 8'h00, sa + 1);
    step();
    check("wrap_drain_valid", 32'(evt_if.evt_valid_out), 32'd0);
    check("wrap_drop",        32'(drop_cnt_out),         32'd0);
    evt_if.evt_ready_in = 1'b0;

    // DEPTH+2 overflow edges with no consumer: two are lost.
    for (int i = 0; i < 12; i++) begin
      cnt_in = 8'(8'h10 + i);
      ovf_in = (i % 2 == 0);
      if (i % 2 == 0 && i / 2 < 4) stq[i / 2] = edges;
      step();
      if (i == 4) check("fill_not_full", 32'(fifo_full_out), 32'd0);
      if (i == 6) check("fill_full",     32'(fifo_full_out), 32'd1);
    end
    check("fill_drop", 32'(drop_cnt_out), 32'd2);
    ovf_in = 1'b0;
    evt_if.evt_ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_head($sformatf("drain%0d", k), EVT_OVF, 8'(8'h10 + 2 * k), stq[k]);
      step();
    end
    check("drain_valid", 32'(evt_if.evt_valid_out), 32'd0);
    check("drain_full",  32'(fifo_full_out),        32'd0);
    evt_if.evt_ready_in = 1'b0;

    // Full queue: a new event with a simultaneous pop is accepted.
    for (int i = 0; i < 8; i++) begin
      cnt_in = 8'(8'h20 + i);
      ovf_in = (i % 2 == 0);
      step();
    end
    check("full2_full", 32'(fifo_full_out), 32'd1);
    check("full2_drop", 32'(drop_cnt_out),  32'd2);
    cnt_in = 8'h30;
    ovf_in = 1'b1;
    evt_if.evt_ready_in = 1'b1;
    step();
    ovf_in = 1'b0;
    check("pp_full",  32'(fifo_full_out),        32'd1);
    check("pp_drop",  32'(drop_cnt_out),         32'd2);
    check("pp_valid", 32'(evt_if.evt_valid_out), 32'd1);
    exp5[0] = 8'h22; exp5[1] = 8'h24; exp5[2] = 8'h26; exp5[3] = 8'h30;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("pp_order%0d", k), 32'(evt_if.evt_data_out), 32'(exp5[k]));
      step();
    end
    check("pp_empty", 32'(evt_if.evt_valid_out), 32'd0);
    evt_if.evt_ready_in = 1'b0;

    // OVF and THR on the same edge: OVF queued, THR counted as lost.
    thr_in = 8'hFF;
    thr_en_in = 1'b1;
    cnt_in = 8'hFE; step();
    cnt_in = 8'hFF; ovf_in = 1'b1;
    st = edges;
    step();
    check_head("ovfthr", EVT_OVF, 8'hFF, st);
    check("ovfthr_drop", 32'(drop_cnt_out), 32'd3);

    // Asynchronous reset with an entry queued.
    nrst_in = 1'b0;
    #1;
    check_idle("midrst");
    thr_en_in = 1'b0;
    #1;
    nrst_in = 1'b1;
    edges   = 0;
    // First edge after reset sees prev=0: 0xFF with ovf gives OVF, WRAP lost.
    step();
    check_head("post_rst", EVT_OVF, 8'hFF, 0);
    check("post_rst_drop", 32'(drop_cnt_out), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_event_capture.md
# counter_event_capture

Downstream monitor for the 8-bit up/down counter stage. Samples the counter value and overflow flag every cycle and detects three events: overflow assertion, wrap-around, and threshold match. Events are timestamped and queued in a small FIFO drained over a valid/ready interface by the status/interrupt logic.

## Interface
Parameters:
- DEPTH, 4: event FIFO depth; power of two, 2..16.
- STAMP_W, 16: timestamp width.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- nrst_in  input  1  reset, asynchronous, active-low.
- cnt_in  input  8  counter value from the counter stage's counter_out.
- ovf_in  input  1  overflow flag from the counter stage's ovf_out.
- thr_in  input  8  threshold value, quasi-static.
- thr_en_in  input  1  enables threshold-match detection.
- evt_ready_in  input  1  consumer accepts the head event.
- evt_valid_out  output  1  FIFO non-empty.
- evt_code_out  output  2  head event code.
- evt_data_out  output  8  cnt_in value at detection.
- evt_stamp_out  output  STAMP_W  timestamp at detection.
- fifo_full_out  output  1  FIFO holds DEPTH entries.
- drop_cnt_out  output  8  saturating count of lost events.

## Operation
- Registers prev_cnt and prev_ovf hold the previous-edge samples of cnt_in and ovf_in. Both reset to 0.
- Event detection at each edge, comparing the current inputs against the prev registers:
  - OVF (code 2'b01): ovf_in==1 and prev_ovf==0.
  - WRAP (code 2'b11): (prev_cnt==8'hFF and cnt_in==8'h00) or (prev_cnt==8'h00 and cnt_in==8'hFF).
  - THR (code 2'b10): thr_en_in==1, cnt_in==thr_in, and prev_cnt!=thr_in.
  - Code 2'b00 is never pushed.
- At most one push per cycle. Priority is OVF > WRAP > THR.
  - Each simultaneous lower-priority event increments drop_cnt by 1.
- Push when an event is detected and the FIFO can accept it.
  - The FIFO can accept when it is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the event is discarded and drop_cnt increments.
  - drop_cnt adds the total losses of the cycle (0..3) and saturates at 8'hFF.
- Pop when evt_valid_out and evt_ready_in are both high.
  - evt_ready_in while empty has no effect.
- Push and pop in the same cycle leave the occupancy unchanged.
- Each entry stores {code, cnt_in, stamp}.
- stamp is a free-running STAMP_W counter that increments every cycle and wraps to 0. An event records the stamp value before that edge's increment.
- FIFO pointers are log2(DEPTH)+1 bits wide, and the extra MSB distinguishes full from empty.

## Timing
- Reset (asynchronous, immediate) drives all outputs and state to 0:
  - evt_valid_out, evt_code_out, evt_data_out, evt_stamp_out, fifo_full_out, drop_cnt_out
  - FIFO pointers, stamp, prev_cnt, prev_ovf
- Reset mid-operation discards all queued entries.
- After deassertion, the first edge compares against prev_cnt=0 and prev_ovf=0.
  - A value of 0xFF sampled on that first edge therefore raises both OVF and WRAP; OVF is pushed and WRAP is dropped.
- Latency: an event sampled at edge k is visible on the outputs after edge k if the FIFO was empty before that edge. Otherwise it appears once it reaches the head.
- Outputs are driven from FIFO storage or registers; there is no combinational path from inputs to outputs.
- Valid/ready rules:
  - evt_valid_out stays high and the head fields stay stable until a pop.
  - The head advances on the edge where the pop occurs.
- fifo_full_out updates on the same edge as occupancy.

## Structure
- Package counter_evt_pkg holds:
  - localparams EVT_OVF, EVT_THR, EVT_WRAP;
  - typedef evt_t = struct {code[1:0], data[7:0], stamp[STAMP_W-1:0]} (STAMP_W passed as package parameter default 16).
- Sub-module evt_fifo: synchronous FIFO with parameters DEPTH and WIDTH, push/pop inputs and full/empty outputs.
- Detection, priority logic, stamp counter and drop counter live in the top level.

## Test plan
- Reset, then cnt_in ramps 0x00..0x05 with thr_en_in=0 → no events, drop_cnt_out=0, evt_valid_out=0.
- thr_in=0x03, thr_en_in=1, ramp 0x00→0x05, evt_ready_in=1 → exactly one entry {2'b10, 0x03, stamp=cycle of 0x03 sample}; holding cnt_in at 0x03 pushes nothing further.
- Ramp 0xFD→0xFF→0x00 with ovf_in following 0xFF → OVF entry (data 0xFF), then WRAP entry (data 0x00), with consecutive stamps.
- evt_ready_in=0 with DEPTH+2 distinct events → fifo_full_out=1 after DEPTH events, drop_cnt_out=2; then draining with ready=1 returns events in order.
- With the FIFO full, an event and a pop on the same cycle → push accepted, occupancy stays DEPTH, drop_cnt_out unchanged.
- thr_in=0xFF: 0xFE→0xFF with ovf rising → one OVF push, drop_cnt_out +1; assert nrst_in low mid-queue → all outputs 0 immediately.
